reg_show_display: RTL and testbench

REG_SHOW_DISPLAY -- requirements
Module: reg_show_display

---
 rtl/reg_show_display.sv | 152 +++++++++++++++
 tb/tb_reg_show_display.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_show_display.sv
// Four-digit multiplexed seven-segment driver showing two captured 8-bit register values in hex.
// Digits 0/1 show register 1 (low/high nibble), digits 2/3 show register 2; the decimal point marks the last-updated value.
module reg_show_display #(
  parameter int SCAN_DIV = 1000,
  parameter int BLANK    = 8
) (
  input  logic       i_CLK,
  input  logic       i_RST,
  input  logic       i_ShowR1,
  input  logic       i_ShowR2,
  input  logic [7:0] i_RegShowing1,
  input  logic [7:0] i_RegShowing2,
  output logic [3:0] o_AN,
  output logic [6:0] o_SEG,
  output logic       o_DP
);

  localparam logic [15:0] CNT_LAST = 16'(SCAN_DIV - 1);
  localparam logic [16:0] BLANK_W  = 17'(BLANK);
  localparam logic [6:0]  SEG_OFF  = 7'b1111111;

  logic [7:0]  h1_q, h1_d;
  logic [7:0]  h2_q, h2_d;
  logic        v1_q, v1_d;
  logic        v2_q, v2_d;
  logic        l_q, l_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;

  logic        blank_slot;
  logic [3:0]  nibble;
  logic        digit_valid;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Capture path: a strobe held high reloads every cycle; register 2 wins the last-updated flag.
  always_comb begin
    h1_d = h1_q;
    h2_d = h2_q;
    v1_d = v1_q;
    v2_d = v2_q;
    l_d  = l_q;
    if (i_ShowR1) begin
      h1_d = i_RegShowing1;
      v1_d = 1'b1;
    end
    if (i_ShowR2) begin
      h2_d = i_RegShowing2;
      v2_d = 1'b1;
    end
    if (i_ShowR2) begin
      l_d = 1'b1;
    end else if (i_ShowR1) begin
      l_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = 16'd0;
      idx_d = idx_q + 2'd1;
    end
  end

  // Outputs are decoded from pre-edge state and registered, giving one cycle of latency.
  always_comb begin
    blank_slot  = ({1'b0, cnt_q} < BLANK_W);
    nibble      = 4'h0;
    digit_valid = 1'b0;
    case (idx_q)
      2'd0: begin
        nibble      = h1_q[3:0];
        digit_valid = v1_q;
      end
      2'd1: begin
        nibble      = h1_q[7:4];
        digit_valid = v1_q;
      end
      2'd2: begin
        nibble      = h2_q[3:0];
        digit_valid = v2_q;
      end
      default: begin
        nibble      = h2_q[7:4];
        digit_valid = v2_q;
      end
    endcase

    an_d  = blank_slot ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d = digit_valid ? hex_to_seg(nibble) : SEG_OFF;
    dp_d  = ~(!blank_slot &&
              (((idx_q == 2'd1) && !l_q && v1_q) ||
               ((idx_q == 2'd3) &&  l_q && v2_q)));
  end

  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      h1_q  <= 8'h00;
      h2_q  <= 8'h00;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      l_q   <= 1'b0;
      cnt_q <= 16'd0;
      idx_q <= 2'd0;
      an_q  <= 4'b1111;
      seg_q <= SEG_OFF;
      dp_q  <= 1'b1;
    end else begin
      h1_q  <= h1_d;
      h2_q  <= h2_d;
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      l_q   <= l_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign o_AN  = an_q;
  assign o_SEG = seg_q;
  assign o_DP  = dp_q;

endmodule

// File: tb/tb_reg_show_display.sv
// Directed bench for reg_show_display with SCAN_DIV=4, BLANK=1, plus a BLANK=0 instance for the no-blanking case.
module tb_reg_show_display;

  logic       clk;
  logic       rst_n;
  logic       show1, show2;
  logic [7:0] reg1, reg2;
  logic [3:0] an, an_nb;
  logic [6:0] seg, seg_nb;
  logic       dp, dp_nb;

  int checks;
  int errors;
  int e;

  reg_show_display #(.SCAN_DIV(4), .BLANK(1)) u_dut (
    .i_CLK(clk), .i_RST(rst_n), .i_ShowR1(show1), .i_ShowR2(show2),
    .i_RegShowing1(reg1), .i_RegShowing2(reg2),
    .o_AN(an), .o_SEG(seg), .o_DP(dp)
  );

  reg_show_display #(.SCAN_DIV(3), .BLANK(0)) u_dut_nb (
    .i_CLK(clk), .i_RST(rst_n), .i_ShowR1(show1), .i_ShowR2(show2),
    .i_RegShowing1(reg1), .i_RegShowing2(reg2),
    .o_AN(an_nb), .o_SEG(seg_nb), .o_DP(dp_nb)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected anodes after edge n of a run (SCAN_DIV=4, BLANK=1): slot start blanked.
  function automatic logic [3:0] exp_an(input int n);
    int p;
    p = n - 1;
    if (p % 4 == 0) return 4'b1111;
    case ((p / 4) % 4)
      0:       return 4'b1110;
      1:       return 4'b1101;
      2:       return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    e = e + 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    show1 = 1'b0;
    show2 = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    e = 0;
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
      errors++;
      $display("FAIL reset_async an=%b seg=%b dp=%b exp 1111 1111111 1", an, seg, dp);
    end
    step();
    step();
    checks++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
      errors++;
      $display("FAIL reset_hold an=%b seg=%b dp=%b exp 1111 1111111 1", an, seg, dp);
    end
    checks++;
    if (an_nb !== 4'b1111) begin
      errors++;
      $display("FAIL reset_nb an=%b exp 1111", an_nb);
    end
  endtask

  task automatic test_idle();
    logic [3:0] nb_exp;
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      step();
      checks++;
      if (an !== exp_an(e) || seg !== 7'b1111111 || dp !== 1'b1) begin
        errors++;
        $display("FAIL idle e=%0d an=%b seg=%b dp=%b exp %b 1111111 1", e, an, seg, dp, exp_an(e));
      end
      case (((e - 1) / 3) % 4)
        0:       nb_exp = 4'b1110;
        1:       nb_exp = 4'b1101;
        2:       nb_exp = 4'b1011;
        default: nb_exp = 4'b0111;
      endcase
      checks++;
      if (an_nb !== nb_exp || seg_nb !== 7'b1111111 || dp_nb !== 1'b1) begin
        errors++;
        $display("FAIL noblank e=%0d an=%b seg=%b dp=%b exp %b 1111111 1", e, an_nb, seg_nb, dp_nb, nb_exp);
      end
    end
  endtask

  task automatic test_single_capture();
    int idx, cnt;
    logic [6:0] es;
    logic       ed;
    do_reset();
    show1 = 1'b1;
    reg1  = 8'h3A;
    step();
    show1 = 1'b0;
    checks++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
      errors++;
      $display("FAIL single_first an=%b seg=%b dp=%b exp 1111 1111111 1", an, seg, dp);
    end
    for (int k = 2; k <= 16; k++) begin
      step();
      idx = ((e - 1) / 4) % 4;
      cnt = (e - 1) % 4;
      es  = (idx == 0) ? 7'b0001000 : (idx == 1) ? 7'b0110000 : 7'b1111111;
      ed  = (idx == 1 && cnt != 0) ? 1'b0 : 1'b1;
      checks++;
      if (an !== exp_an(e) || seg !== es || dp !== ed) begin
        errors++;
        $display("FAIL single e=%0d an=%b seg=%b dp=%b exp %b %b %b", e, an, seg, dp, exp_an(e), es, ed);
      end
    end
  endtask

  task automatic test_simultaneous();
    int idx, cnt;
    logic [6:0] es;
    logic       ed;
    do_reset();
    show1 = 1'b1;
    show2 = 1'b1;
    reg1  = 8'h12;
    reg2  = 8'hF0;
    step();
    show1 = 1'b0;
    show2 = 1'b0;
    for (int k = 2; k <= 16; k++) begin
      step();
      idx = ((e - 1) / 4) % 4;
      cnt = (e - 1) % 4;
      case (idx)
        0:       es = 7'b0100100;
        1:       es = 7'b1111001;
        2:       es = 7'b1000000;
        default: es = 7'b0001110;
      endcase
      ed = (idx == 3 && cnt != 0) ? 1'b0 : 1'b1;
      checks++;
      if (an !== exp_an(e) || seg !== es || dp !== ed) begin
        errors++;
        $display("FAIL simul e=%0d an=%b seg=%b dp=%b exp %b %b %b", e, an, seg, dp, exp_an(e), es, ed);
      end
    end
  endtask

  task automatic test_held_strobe();
    int idx, cnt;
    logic [6:0] es;
    logic       ed;
    do_reset();
    show2 = 1'b1;
    reg2  = 8'h05;
    for (int k = 1; k <= 16; k++) begin
      step();
      idx = ((e - 1) / 4) % 4;
      cnt = (e - 1) % 4;
      if (e == 1)        es = 7'b1111111;
      else if (idx < 2)  es = 7'b1111111;
      else if (idx == 2) es = (e <= 11) ? 7'b0010010 : 7'b0000010;
      else               es = 7'b1000000;
      ed = (idx == 3 && cnt != 0) ? 1'b0 : 1'b1;
      checks++;
      if (an !== exp_an(e) || seg !== es || dp !== ed) begin
        errors++;
        $display("FAIL held e=%0d an=%b seg=%b dp=%b exp %b %b %b", e, an, seg, dp, exp_an(e), es, ed);
      end
      if (e == 10) reg2 = 8'h06;
    end
    show2 = 1'b0;
  endtask

  task automatic test_mid_slot_reset();
    do_reset();
    show1 = 1'b1;
    show2 = 1'b1;
    reg1  = 8'h45;
    reg2  = 8'h67;
    step();
    show1 = 1'b0;
    show2 = 1'b0;
    while (e < 10) step();
    checks++;
    if (an !== 4'b1011 || seg !== 7'b1111000 || dp !== 1'b1) begin
      errors++;
      $display("FAIL midrst_before an=%b seg=%b dp=%b exp 1011 1111000 1", an, seg, dp);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (an !== 4'b1111 || seg !== 7'b1111111 || dp !== 1'b1) begin
      errors++;
      $display("FAIL midrst_async an=%b seg=%b dp=%b exp 1111 1111111 1", an, seg, dp);
    end
    step();
    step();
    rst_n = 1'b1;
    e = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (an !== exp_an(e) || seg !== 7'b1111111 || dp !== 1'b1) begin
        errors++;
        $display("FAIL midrst_after e=%0d an=%b seg=%b dp=%b exp %b 1111111 1", e, an, seg, dp, exp_an(e));
      end
    end
  endtask

  task automatic test_wrap_and_last();
    int idx, cnt, last_start;
    logic [3:0] prev_an;
    logic [6:0] es;
    logic       ed;
    do_reset();
    show1 = 1'b1;
    reg1  = 8'hC9;
    step();
    show1 = 1'b0;
    show2 = 1'b1;
    reg2  = 8'hBD;
    step();
    show2 = 1'b0;
    prev_an    = an;
    last_start = 0;
    for (int k = 3; k <= 68; k++) begin
      step();
      idx = ((e - 1) / 4) % 4;
      cnt = (e - 1) % 4;
      case (idx)
        0:       es = 7'b0010000;
        1:       es = 7'b1000110;
        2:       es = 7'b0100001;
        default: es = 7'b0000011;
      endcase
      if (e <= 53) ed = (idx == 3 && cnt != 0) ? 1'b0 : 1'b1;
      else         ed = (idx == 1 && cnt != 0) ? 1'b0 : 1'b1;
      checks++;
      if (an !== exp_an(e) || seg !== es || dp !== ed) begin
        errors++;
        $display("FAIL wrap e=%0d an=%b seg=%b dp=%b exp %b %b %b", e, an, seg, dp, exp_an(e), es, ed);
      end
      if (an == 4'b1110 && prev_an == 4'b1111) begin
        if (last_start > 0) begin
          checks++;
          if (e - last_start != 16) begin
            errors++;
            $display("FAIL wrap_period e=%0d got %0d exp 16", e, e - last_start);
          end
        end
        last_start = e;
      end
      prev_an = an;
      if (e == 52) show1 = 1'b1;
      if (e == 53) show1 = 1'b0;
    end
    checks++;
    if (last_start != 66) begin
      errors++;
      $display("FAIL wrap_last_start got %0d exp 66", last_start);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    e      = 0;
    rst_n  = 1'b1;
    show1  = 1'b0;
    show2  = 1'b0;
    reg1   = 8'h00;
    reg2   = 8'h00;
    test_reset();
    test_idle();
    test_single_capture();
    test_simultaneous();
    test_held_strobe();
    test_mid_slot_reset();
    test_wrap_and_last();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
